// File: rtl/pulse_pkg.sv
// Shared types for the shaping-filter back end: sample/time widths, detector state, event record.
package pulse_pkg;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int SIZE_TIME        = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // "time" is a reserved word, so the timestamp field is named ts.
    typedef struct packed {
        logic [SIZE_FILTER_DATA-1:0] peak;
        logic [SIZE_TIME-1:0]        ts;
    } evt_t;

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through event buffer; head visible the cycle after the push, one pop per cycle.
// A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
module evt_fifo
    import pulse_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  evt_t          push_dat,
    input  logic          pop,
    output evt_t          head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    evt_t          mem [DEPTH];
    evt_t          last_head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // When drained, keep presenting the last head instead of a stale slot.
    assign head = empty ? last_head : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            last_head <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (!empty) begin
                last_head <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pulse_peak_detector.sv
// Threshold pulse detector: captures peak amplitude/time per pulse, buffers events for readout.
// Event valid two edges after the terminating sample; full buffer without pop drops and counts.
module pulse_peak_detector
    import pulse_pkg::*;
#(
    parameter int HOLDOFF_LEN = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SIZE_FILTER_DATA-1:0] filter_data,
    input  logic [SIZE_FILTER_DATA-1:0] threshold,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [SIZE_FILTER_DATA-1:0] evt_peak,
    output logic [SIZE_TIME-1:0]        evt_time,
    output logic [7:0]                  overflow_cnt,
    output logic                        busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [SIZE_FILTER_DATA-1:0] din_r;
    logic [SIZE_TIME-1:0]        din_t;
    logic [SIZE_TIME-1:0]        ts;
    state_t                      state;
    logic [SIZE_FILTER_DATA-1:0] pk;
    logic [SIZE_TIME-1:0]        pk_t;
    logic [7:0]                  hold_cnt;

    logic          push;
    logic          pop;
    evt_t          push_dat;
    evt_t          head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Each registered sample carries the counter value it was captured with.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_r <= '0;
            din_t <= '0;
            ts    <= '0;
        end else begin
            din_r <= filter_data;
            din_t <= ts;
            ts    <= ts + 1'b1;
        end
    end

    assign push          = (state == ARMED) && (din_r <= threshold);
    assign push_dat.peak = pk;
    assign push_dat.ts   = pk_t;
    assign pop           = evt_valid && evt_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pk       <= '0;
            pk_t     <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_r > threshold) begin
                        pk    <= din_r;
                        pk_t  <= din_t;
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    // The terminating sample closes the event and is never a peak candidate.
                    if (din_r <= threshold) begin
                        hold_cnt <= 8'(HOLDOFF_LEN);
                        state    <= HOLDOFF;
                    end else if (din_r > pk) begin
                        pk   <= din_r;
                        pk_t <= din_t;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt != 8'd0) begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end else if (din_r <= threshold) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_cnt <= '0;
        end else if (push && fifo_full && !pop && (overflow_cnt != 8'hFF)) begin
            overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign evt_valid = !fifo_empty;
    assign evt_peak  = head.peak;
    assign evt_time  = head.ts;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (fifo_count <= CW'(FIFO_DEPTH));
        end
    end

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed-vector bench for pulse_peak_detector with hand-computed peaks, times and drop counts.
module tb_pulse_peak_detector;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] filter_data = '0;
    logic [15:0] threshold = 16'd100;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [15:0] evt_peak;
    logic [31:0] evt_time;
    logic [7:0]  overflow_cnt;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int t      = 0;
    int seq [$];
    logic [31:0] got_pk [$];
    logic [31:0] got_tm [$];
    logic [31:0] got_e  [$];
    int tp [7];
    int t0;

    pulse_peak_detector #(
        .HOLDOFF_LEN (4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .filter_data  (filter_data),
        .threshold    (threshold),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_peak     (evt_peak),
        .evt_time     (evt_time),
        .overflow_cnt (overflow_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive one sample for edge t; log any handshake that completes on that edge.
    task automatic tick(input int d);
        filter_data = 16'(d);
        if (evt_valid && evt_ready) begin
            got_pk.push_back(32'(evt_peak));
            got_tm.push_back(evt_time);
            got_e.push_back(32'(t));
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic zeros(input int n);
        repeat (n) tick(0);
    endtask

    task automatic play();
        foreach (seq[i]) tick(seq[i]);
    endtask

    task automatic clear_got();
        got_pk.delete();
        got_tm.delete();
        got_e.delete();
    endtask

    initial begin
        // Reset and release just after an edge so the next sample is time 0.
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        t = 0;
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_peak", 32'(evt_peak), 0);
        chk("rst_time", evt_time, 0);
        chk("rst_ovf", 32'(overflow_cnt), 0);
        chk("rst_busy", 32'(busy), 0);

        // 1: single pulse
        clear_got();
        t0 = t;
        seq = '{0, 50, 150, 300, 250, 90};
        play();
        chk("t1_valid_early", 32'(evt_valid), 0);
        tick(0);
        chk("t1_valid_push", 32'(evt_valid), 1);
        zeros(8);
        chk("t1_count", 32'(got_pk.size()), 1);
        if (got_pk.size() >= 1) begin
            chk("t1_peak", got_pk[0], 300);
            chk("t1_time", got_tm[0], 32'(t0 + 3));
            chk("t1_edge", got_e[0], 32'(t0 + 7));
        end
        chk("t1_valid_after", 32'(evt_valid), 0);
        chk("t1_busy_idle", 32'(busy), 0);

        // 2: flat top, first occurrence wins; sample equal to threshold ends pulse
        clear_got();
        t0 = t;
        seq = '{0, 200, 400, 400, 100, 0};
        play();
        zeros(8);
        chk("t2_count", 32'(got_pk.size()), 1);
        if (got_pk.size() >= 1) begin
            chk("t2_peak", got_pk[0], 400);
            chk("t2_time", got_tm[0], 32'(t0 + 2));
            chk("t2_edge", got_e[0], 32'(t0 + 6));
        end

        // 3: crossing during holdoff is ignored; re-arm only after a low sample
        clear_got();
        t0 = t;
        seq = '{0, 200, 50, 0, 0, 300, 300, 300, 300, 300, 50, 0, 500, 600, 50, 0};
        play();
        zeros(8);
        chk("t3_count", 32'(got_pk.size()), 2);
        if (got_pk.size() >= 2) begin
            chk("t3_peak_a", got_pk[0], 200);
            chk("t3_time_a", got_tm[0], 32'(t0 + 1));
            chk("t3_peak_b", got_pk[1], 600);
            chk("t3_time_b", got_tm[1], 32'(t0 + 13));
        end

        // 4: six pulses into a stalled consumer
        evt_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tp[j] = t;
            tick(1000 + j);
            zeros(7);
        end
        chk("t4_ovf", 32'(overflow_cnt), 2);
        chk("t4_valid", 32'(evt_valid), 1);
        chk("t4_head_peak", 32'(evt_peak), 1000);
        chk("t4_head_time", evt_time, 32'(tp[0]));

        // 5: push coincides with pop on a full buffer
        tp[6] = t;
        tick(2000);
        tick(0);
        evt_ready = 1'b1;
        tick(0);
        evt_ready = 1'b0;
        chk("t5_ovf", 32'(overflow_cnt), 2);
        chk("t5_head_peak", 32'(evt_peak), 1001);
        chk("t5_head_time", evt_time, 32'(tp[1]));
        zeros(6);
        chk("t5_hold_peak", 32'(evt_peak), 1001);

        clear_got();
        evt_ready = 1'b1;
        zeros(6);
        chk("t5_drain_count", 32'(got_pk.size()), 4);
        if (got_pk.size() >= 4) begin
            for (int k = 0; k < 3; k++) begin
                chk("t5_drain_peak", got_pk[k], 32'(1001 + k));
                chk("t5_drain_time", got_tm[k], 32'(tp[k + 1]));
            end
            chk("t5_drain_peak_new", got_pk[3], 2000);
            chk("t5_drain_time_new", got_tm[3], 32'(tp[6]));
        end
        chk("t5_empty", 32'(evt_valid), 0);
        chk("t5_ovf_after", 32'(overflow_cnt), 2);

        // 6: asynchronous reset while armed with two events buffered
        evt_ready = 1'b0;
        tick(3001);
        zeros(7);
        tick(3002);
        zeros(7);
        tick(3100);
        tick(3100);
        chk("t6_busy_pre", 32'(busy), 1);
        chk("t6_valid_pre", 32'(evt_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_valid_rst", 32'(evt_valid), 0);
        chk("t6_peak_rst", 32'(evt_peak), 0);
        chk("t6_time_rst", evt_time, 0);
        chk("t6_ovf_rst", 32'(overflow_cnt), 0);
        chk("t6_busy_rst", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        t = 0;
        evt_ready = 1'b1;
        clear_got();
        seq = '{0, 400, 0};
        play();
        zeros(8);
        chk("t6_count", 32'(got_pk.size()), 1);
        if (got_pk.size() >= 1) begin
            chk("t6_peak", got_pk[0], 400);
            chk("t6_time", got_tm[0], 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
